product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/mult_pkg.sv | 14 +
 rtl/product_accumulator.sv | 142 ++++++++++++++
 tb/tb_product_accumulator.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier / product-accumulator datapath.
package mult_pkg;

  localparam int unsigned PROD_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 8;
  localparam int unsigned ACC_W_DEF  = PROD_W_DEF + CNT_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } acc_state_e;

endpackage : mult_pkg

// File: rtl/product_accumulator.sv
// Accumulates a counted burst of signed products into a full-width sum and
// hands the result out through a valid/ready handshake.
module product_accumulator
  import mult_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              abort,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  result,
  output logic              busy
);

  localparam int unsigned EXT_W = ACC_W - PROD_W;

  acc_state_e        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  rem_q, rem_d;

  logic              prod_ready_q, prod_ready_d;
  logic              res_valid_q, res_valid_d;
  logic              busy_q, busy_d;
  logic [ACC_W-1:0]  result_q, result_d;

  logic              xfer_c;
  logic              res_hs_c;
  logic [ACC_W-1:0]  prod_ext_c;

  // Handshake qualifiers; abort suppresses both in its cycle.
  assign xfer_c     = prod_valid && prod_ready_q && !abort;
  assign res_hs_c   = res_valid_q && res_ready && !abort;
  assign prod_ext_c = {{EXT_W{prod[PROD_W-1]}}, prod};

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = (len == '0) ? ST_DONE : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (xfer_c && (rem_q == CNT_W'(1))) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_hs_c) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Accumulator and remaining-count next values.
  always_comb begin
    acc_d = acc_q;
    rem_d = rem_q;
    if (abort) begin
      acc_d = '0;
      rem_d = '0;
    end else if ((state_q == ST_IDLE) && start) begin
      acc_d = '0;
      rem_d = len;
    end else if (xfer_c) begin
      acc_d = acc_q + prod_ext_c;
      rem_d = rem_q - CNT_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      rem_q <= '0;
    end else begin
      acc_q <= acc_d;
      rem_q <= rem_d;
    end
  end

  // Output next values derived from the upcoming state, so the registered
  // outputs line up with the state they describe.
  always_comb begin
    prod_ready_d = 1'b0;
    res_valid_d  = 1'b0;
    busy_d       = 1'b0;
    result_d     = '0;
    prod_ready_d = (state_d == ST_ACCUM);
    res_valid_d  = (state_d == ST_DONE);
    busy_d       = (state_d != ST_IDLE);
    if (state_d == ST_DONE) begin
      result_d = acc_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_ready_q <= 1'b0;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      result_q     <= '0;
    end else begin
      prod_ready_q <= prod_ready_d;
      res_valid_q  <= res_valid_d;
      busy_q       <= busy_d;
      result_q     <= result_d;
    end
  end

  assign prod_ready = prod_ready_q;
  assign res_valid  = res_valid_q;
  assign busy       = busy_q;
  assign result     = result_q;

endmodule : product_accumulator

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator with a sum-of-products model.
module tb_product_accumulator;

  localparam int unsigned PROD_W = 32;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ACC_W  = 40;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [CNT_W-1:0]  len;
  logic              abort;
  logic              prod_valid;
  logic [PROD_W-1:0] prod;
  logic              prod_ready;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  result;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  product_accumulator #(
    .PROD_W (PROD_W),
    .CNT_W  (CNT_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .abort      (abort),
    .prod_valid (prod_valid),
    .prod       (prod),
    .prod_ready (prod_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .result     (result),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation: start, feed n products (with optional bubbles),
  // hold the result for 'hold' cycles, then complete the handshake.
  task automatic run_op(input int n, input bit fixed, input logic [PROD_W-1:0] pval,
                        input int bubble_pct, input int hold, input bit poke_start);
    longint           sum;
    int               cnt;
    int               guard;
    logic [PROD_W-1:0] p;
    bit               v;
    logic [ACC_W-1:0] exp;
    sum   = 0;
    cnt   = 0;
    guard = 0;
    start = 1'b1;
    len   = CNT_W'(n);
    step();
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    while (cnt < n && guard < 4000) begin
      p = fixed ? pval : PROD_W'($urandom);
      v = ($urandom_range(99) >= bubble_pct);
      chk("prod_ready_accum", 64'(prod_ready), 64'd1);
      chk("res_valid_accum", 64'(res_valid), 64'd0);
      chk("result_zero_accum", 64'(result), 64'd0);
      prod_valid = v;
      prod       = p;
      start      = poke_start ? 1'($urandom_range(1)) : 1'b0;
      len        = CNT_W'($urandom);
      step();
      if (v) begin
        sum += longint'(signed'(p));
        cnt++;
      end
      guard++;
    end
    if (guard >= 4000) chk("transfer_timeout", 64'd0, 64'd1);
    prod_valid = 1'b0;
    start      = 1'b0;
    exp        = ACC_W'(sum);
    chk("prod_ready_done", 64'(prod_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      chk("res_valid_hold", 64'(res_valid), 64'd1);
      chk("result_hold", 64'(result), 64'(exp));
      res_ready = 1'b0;
      start     = poke_start;
      step();
    end
    chk("res_valid_final", 64'(res_valid), 64'd1);
    chk("result_final", 64'(result), 64'(exp));
    res_ready = 1'b1;
    start     = poke_start;
    step();
    res_ready = 1'b0;
    start     = 1'b0;
    chk("res_valid_after_hs", 64'(res_valid), 64'd0);
    chk("result_after_hs", 64'(result), 64'd0);
    chk("busy_after_hs", 64'(busy), 64'd0);
    chk("prod_ready_after_hs", 64'(prod_ready), 64'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_prod_ready"}, 64'(prod_ready), 64'd0);
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_result"}, 64'(result), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    len        = '0;
    abort      = 1'b0;
    prod_valid = 1'b0;
    prod       = '0;
    res_ready  = 1'b0;

    // Reset state
    #12;
    chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Start accepted on first edge after reset release: 100, -250, 7
    start = 1'b1;
    len   = CNT_W'(3);
    step();
    start = 1'b0;
    chk("d034_busy", 64'(busy), 64'd1);
    prod_valid = 1'b1;
    prod = PROD_W'(100);
    step();
    chk("d034_rv1", 64'(res_valid), 64'd0);
    prod = PROD_W'(-250);
    step();
    chk("d034_rv2", 64'(res_valid), 64'd0);
    prod = PROD_W'(7);
    step();
    prod_valid = 1'b0;
    chk("d034_res_valid", 64'(res_valid), 64'd1);
    chk("d034_result", 64'(result), 64'(40'hFF_FFFF_FF71));
    chk("d034_prod_ready", 64'(prod_ready), 64'd0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk_idle("d034_end");

    // len = 0
    run_op(0, 1'b1, '0, 0, 2, 1'b0);

    // 2^30 four times with bubbles and a held-off result
    run_op(4, 1'b1, 32'h4000_0000, 40, 5, 1'b0);

    // Abort after two transfers, overriding start/transfer/handshake
    start = 1'b1;
    len   = CNT_W'(5);
    step();
    start      = 1'b0;
    prod_valid = 1'b1;
    prod       = PROD_W'($urandom);
    step();
    step();
    abort     = 1'b1;
    start     = 1'b1;
    res_ready = 1'b1;
    step();
    abort      = 1'b0;
    start      = 1'b0;
    res_ready  = 1'b0;
    prod_valid = 1'b0;
    chk_idle("abort_accum");
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_res_valid", 64'(res_valid), 64'd0);
      step();
    end
    run_op(1, 1'b1, 32'hFFFF_FFFF, 0, 0, 1'b0);

    // Abort while DONE drops the result
    start = 1'b1;
    len   = '0;
    step();
    start = 1'b0;
    chk("abort_done_pre", 64'(res_valid), 64'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("abort_done");

    // Asynchronous reset mid-ACCUM
    start = 1'b1;
    len   = CNT_W'(4);
    step();
    start      = 1'b0;
    prod_valid = 1'b1;
    prod       = PROD_W'(123);
    step();
    prod_valid = 1'b0;
    chk("rst_mid_busy_pre", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("rst_mid_accum");
    step();
    step();
    chk_idle("rst_mid_hold");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2, 1'b0, '0, 20, 1, 1'b0);

    // Randomized operations with ignored start pulses
    for (int k = 0; k < 8; k++) begin
      run_op(int'($urandom_range(20, 1)), 1'b0, '0, int'($urandom_range(50)),
             int'($urandom_range(4)), 1'b1);
    end

    // Maximum length with largest positive product
    run_op(255, 1'b1, 32'h7FFF_FFFF, 0, 1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_product_accumulator
